// File: rtl/spi_pkg.sv
// Shared definitions for the arbitrated SPI master: FSM states, mode-0 levels and widths.
package spi_pkg;

    localparam int unsigned N_REQ       = 2;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned LEN_W       = 4;
    localparam int unsigned CLK_DIV_DEF = 4;

    localparam bit               MSB_FIRST_DEF = 1'b1;
    localparam logic             SCK_IDLE      = 1'b0;
    localparam logic [N_REQ-1:0] SS_IDLE       = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_HOLD,
        ST_GAP
    } spi_state_e;

    // Bit that leaves the shifter first for the chosen bit order
    function automatic logic first_bit(input logic [BYTE_W-1:0] d, input bit msb_first);
        return msb_first ? d[BYTE_W-1] : d[0];
    endfunction

endpackage

// File: rtl/spi_master_arb_if.sv
// Requester command bus plus SPI pins of the shared master.
interface spi_master_arb_if;
    import spi_pkg::*;

    logic [N_REQ-1:0]        req;
    logic [N_REQ*LEN_W-1:0]  len;
    logic [N_REQ*BYTE_W-1:0] tx_data;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        tx_take;
    logic [BYTE_W-1:0]       rx_data;
    logic [N_REQ-1:0]        rx_valid;
    logic [N_REQ-1:0]        done;
    logic                    sck;
    logic [N_REQ-1:0]        ss_n;
    logic                    sdo;
    logic                    sdi;

    modport master (
        input  req, len, tx_data, sdi,
        output gnt, tx_take, rx_data, rx_valid, done, sck, ss_n, sdo
    );

    modport slave (
        output req, len, tx_data, sdi,
        input  gnt, tx_take, rx_data, rx_valid, done, sck, ss_n, sdo
    );

endinterface

// File: rtl/spi_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, last-served requester drops to lowest priority.
module spi_rr_arb2 (
    input  logic       clk,
    input  logic       rstb,
    input  logic [1:0] i_req,
    input  logic       i_upd,
    input  logic       i_upd_idx,
    output logic [1:0] o_gnt_c
);

    logic r_prio;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_prio <= 1'b0;
        end else if (i_upd) begin
            r_prio <= ~i_upd_idx;
        end
    end

    // A single request is already one-hot; only a tie consults the pointer
    always_comb begin
        o_gnt_c = i_req;
        if (i_req == 2'b11) begin
            o_gnt_c = r_prio ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/spi_master_arb.sv
// Mode-0 SPI burst engine shared by two requesters; shifters, counters and FSM live here.
module spi_master_arb
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV   = CLK_DIV_DEF,
    parameter bit          MSB_FIRST = MSB_FIRST_DEF
) (
    input  logic             clk,
    input  logic             rstb,
    spi_master_arb_if.master bus
);

    localparam int unsigned      DIV_W    = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

    spi_state_e        r_state, w_state_nxt;
    logic [DIV_W-1:0]  r_div;
    logic [2:0]        r_bit;
    logic [LEN_W-1:0]  r_byte;
    logic              r_last;
    logic              r_idx;
    logic [BYTE_W-1:0] r_tx_sh, r_rx_sh, r_rx_data;
    logic [N_REQ-1:0]  r_gnt, r_tx_take, r_rx_valid, r_done, r_ss_n;
    logic              r_sck, r_sdo;

    logic [N_REQ-1:0]  w_arb_gnt_c, w_idx_oh;
    logic              w_div_end, w_any_req, w_gnt_hi, w_sel_idx;
    logic              w_grant, w_rise, w_fall, w_byte_end, w_more, w_release, w_finish;
    logic [LEN_W-1:0]  w_len_sel;
    logic [BYTE_W-1:0] w_tx_sel, w_tx_next, w_rx_next;

    spi_rr_arb2 u_arb (
        .clk       (clk),
        .rstb      (rstb),
        .i_req     (bus.req),
        .i_upd     (w_finish),
        .i_upd_idx (r_idx),
        .o_gnt_c   (w_arb_gnt_c)
    );

    assign w_any_req = |bus.req;
    assign w_div_end = (r_div == '0);
    assign w_gnt_hi  = w_arb_gnt_c[1];
    assign w_idx_oh  = {r_idx, ~r_idx};
    assign w_len_sel = w_gnt_hi ? bus.len[2*LEN_W-1:LEN_W] : bus.len[LEN_W-1:0];

    // At grant the arbiter picks the byte source; mid-burst it is the latched owner
    assign w_sel_idx = (r_state == ST_IDLE) ? w_gnt_hi : r_idx;
    assign w_tx_sel  = w_sel_idx ? bus.tx_data[2*BYTE_W-1:BYTE_W] : bus.tx_data[BYTE_W-1:0];
    assign w_tx_next = MSB_FIRST ? {r_tx_sh[BYTE_W-2:0], 1'b0} : {1'b0, r_tx_sh[BYTE_W-1:1]};
    assign w_rx_next = MSB_FIRST ? {r_rx_sh[BYTE_W-2:0], bus.sdi} : {bus.sdi, r_rx_sh[BYTE_W-1:1]};

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_any_req) w_state_nxt = ST_SETUP;
            ST_SETUP: if (w_div_end) w_state_nxt = ST_HIGH;
            ST_HIGH:  if (w_div_end) w_state_nxt = ST_LOW;
            ST_LOW:   if (w_div_end) w_state_nxt = r_last ? ST_HOLD : ST_HIGH;
            ST_HOLD:  if (w_div_end) w_state_nxt = ST_GAP;
            ST_GAP:   if (w_div_end) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath strobes decoded from the current state and divider
    always_comb begin
        w_grant    = 1'b0;
        w_rise     = 1'b0;
        w_fall     = 1'b0;
        w_byte_end = 1'b0;
        w_more     = 1'b0;
        w_release  = 1'b0;
        w_finish   = 1'b0;
        case (r_state)
            ST_IDLE:  w_grant   = w_any_req;
            ST_SETUP: w_rise    = w_div_end;
            ST_HIGH: begin
                w_fall     = w_div_end;
                w_byte_end = w_div_end && (r_bit == 3'd7);
                w_more     = w_div_end && (r_bit == 3'd7) && (r_byte != '0);
            end
            ST_LOW:   w_rise    = w_div_end && !r_last;
            ST_HOLD:  w_release = w_div_end;
            ST_GAP:   w_finish  = w_div_end;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_div <= DIV_LOAD;
        end else if (r_state != w_state_nxt) begin
            r_div <= DIV_LOAD;
        end else if (r_state != ST_IDLE && !w_div_end) begin
            r_div <= r_div - DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_idx      <= 1'b0;
            r_bit      <= '0;
            r_byte     <= '0;
            r_last     <= 1'b0;
            r_tx_sh    <= '0;
            r_rx_sh    <= '0;
            r_rx_data  <= '0;
            r_gnt      <= '0;
            r_tx_take  <= '0;
            r_rx_valid <= '0;
            r_done     <= '0;
            r_ss_n     <= SS_IDLE;
            r_sck      <= SCK_IDLE;
            r_sdo      <= 1'b0;
        end else begin
            r_tx_take  <= '0;
            r_rx_valid <= '0;
            r_done     <= '0;
            if (w_grant) begin
                r_idx     <= w_gnt_hi;
                r_gnt     <= w_arb_gnt_c;
                r_ss_n    <= ~w_arb_gnt_c;
                r_byte    <= w_len_sel - LEN_W'(1);
                r_bit     <= '0;
                r_last    <= 1'b0;
                r_tx_sh   <= w_tx_sel;
                r_sdo     <= first_bit(w_tx_sel, MSB_FIRST);
                r_tx_take <= w_arb_gnt_c;
            end
            if (w_rise) begin
                r_sck   <= 1'b1;
                r_rx_sh <= w_rx_next;
            end
            if (w_fall) begin
                r_sck <= SCK_IDLE;
                r_bit <= r_bit + 3'd1;
                if (w_byte_end) begin
                    r_rx_data  <= r_rx_sh;
                    r_rx_valid <= w_idx_oh;
                    // Next byte goes out on the same falling edge, no inter-byte gap
                    if (w_more) begin
                        r_byte    <= r_byte - LEN_W'(1);
                        r_tx_sh   <= w_tx_sel;
                        r_sdo     <= first_bit(w_tx_sel, MSB_FIRST);
                        r_tx_take <= w_idx_oh;
                    end else begin
                        r_last <= 1'b1;
                    end
                end else begin
                    r_tx_sh <= w_tx_next;
                    r_sdo   <= first_bit(w_tx_next, MSB_FIRST);
                end
            end
            if (w_release) begin
                r_ss_n <= SS_IDLE;
                r_sdo  <= 1'b0;
            end
            if (w_finish) begin
                r_done <= w_idx_oh;
                r_gnt  <= '0;
            end
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.tx_take  = r_tx_take;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.done     = r_done;
    assign bus.sck      = r_sck;
    assign bus.ss_n     = r_ss_n;
    assign bus.sdo      = r_sdo;

endmodule

// File: tb/tb_spi_master_arb.sv
// Self-checking bench: loopback and spi_slave-style model, randomized bursts vs. a transaction-level reference.
module tb_spi_master_arb;
    import spi_pkg::*;

    localparam int unsigned DIV       = 2;
    localparam int          BURST_MAX = 3 * DIV + 16 * 16 * DIV + 40;

    logic clk  = 1'b0;
    logic rstb = 1'b1;
    always #5 clk = ~clk;

    spi_master_arb_if bus();

    spi_master_arb #(.CLK_DIV(DIV), .MSB_FIRST(1'b1)) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    bit   loop_en = 1'b1;
    logic slv_sdo = 1'b0;
    assign bus.sdi = loop_en ? bus.sdo : slv_sdo;

    logic [7:0] exp_tx[$];
    logic [7:0] exp_slv[$];

    // Requester drivers: present the next queued byte after each tx_take
    logic [7:0] drv_q0[$];
    logic [7:0] drv_q1[$];
    always @(negedge clk) begin
        if (rstb) begin
            if (bus.tx_take[0]) begin
                if (drv_q0.size() > 0) void'(drv_q0.pop_front());
                bus.tx_data[7:0] = (drv_q0.size() > 0) ? drv_q0[0] : 8'($urandom);
            end
            if (bus.tx_take[1]) begin
                if (drv_q1.size() > 0) void'(drv_q1.pop_front());
                bus.tx_data[15:8] = (drv_q1.size() > 0) ? drv_q1[0] : 8'($urandom);
            end
        end
    end

    // spi_slave-style device, MSB first: shift out on sck fall, sample on sck rise
    logic [7:0] slv_tx_q[$];
    logic [7:0] slv_rx_q[$];
    logic [7:0] s_cur = 8'h00;
    logic [7:0] s_rx  = 8'h00;
    int         s_cnt = 0;
    always @(bus.ss_n) begin
        if (bus.ss_n != 2'b11) begin
            s_cnt   = 0;
            s_cur   = (slv_tx_q.size() > 0) ? slv_tx_q.pop_front() : 8'h00;
            slv_sdo = s_cur[7];
        end
    end
    always @(posedge bus.sck) begin
        s_rx = {s_rx[6:0], bus.sdo};
        s_cnt++;
        if (s_cnt == 8) begin
            slv_rx_q.push_back(s_rx);
            s_cnt = 0;
        end
    end
    always @(negedge bus.sck) begin
        if (bus.ss_n != 2'b11) begin
            if (s_cnt == 0) s_cur = (slv_tx_q.size() > 0) ? slv_tx_q.pop_front() : 8'h00;
            else            s_cur = {s_cur[6:0], 1'b0};
            slv_sdo = s_cur[7];
        end
    end

    // Bus monitor sampled on the falling clk edge
    int         cyc = 0;
    int         m_rises, m_sdo_n, m_viol, m_t0, m_dur, m_rv_at_done;
    int         m_take[2], m_rv[2], m_done[2], m_ss_rel[2];
    logic [7:0] m_sdo_sh;
    logic [7:0] m_sdo_q[$];
    logic [7:0] m_rx_q[$];
    int         m_grant_q[$];
    logic       m_prev_sck = 1'b0;
    logic [1:0] m_prev_gnt = 2'b00;
    logic [1:0] m_prev_ss  = 2'b11;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rstb) begin
            if (bus.ss_n == 2'b00) m_viol++;
            if (bus.sck && bus.ss_n == 2'b11) m_viol++;
            if (!(bus.gnt inside {2'b00, 2'b01, 2'b10})) m_viol++;
            if (bus.sck && !m_prev_sck) begin
                m_rises++;
                m_sdo_sh = {m_sdo_sh[6:0], bus.sdo};
                m_sdo_n++;
                if (m_sdo_n == 8) begin
                    m_sdo_q.push_back(m_sdo_sh);
                    m_sdo_n = 0;
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (bus.tx_take[i]) m_take[i]++;
                if (bus.rx_valid[i]) begin
                    m_rv[i]++;
                    m_rx_q.push_back(bus.rx_data);
                end
                if (bus.done[i]) m_done[i]++;
                if (bus.ss_n[i] && !m_prev_ss[i]) m_ss_rel[i]++;
            end
            if (bus.gnt != 2'b00 && m_prev_gnt == 2'b00) begin
                m_grant_q.push_back(bus.gnt[1] ? 1 : 0);
                m_t0 = cyc;
            end
            if (bus.done != 2'b00) begin
                m_dur        = cyc - m_t0;
                m_rv_at_done = m_rv[0] + m_rv[1];
            end
        end
        m_prev_sck = bus.sck;
        m_prev_gnt = bus.gnt;
        m_prev_ss  = bus.ss_n;
    end

    task automatic clear_mon();
        m_rises = 0; m_sdo_n = 0; m_viol = 0; m_t0 = 0; m_dur = -1; m_rv_at_done = -1;
        for (int i = 0; i < 2; i++) begin
            m_take[i] = 0; m_rv[i] = 0; m_done[i] = 0; m_ss_rel[i] = 0;
        end
        m_sdo_q.delete(); m_rx_q.delete(); m_grant_q.delete();
    endtask

    task automatic do_reset();
        bus.req = 2'b00; bus.len = 8'h00; bus.tx_data = 16'h0000;
        rstb = 1'b0;
        drv_q0.delete(); drv_q1.delete(); slv_tx_q.delete(); slv_rx_q.delete();
        repeat (3) @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        clear_mon();
    endtask

    // Issue one burst; stop_rv>0 returns once that many bytes were received
    task automatic run_burst(input int idx, input int lenf, input bit loop, input int stop_rv);
        int k;
        clear_mon();
        loop_en = loop;
        slv_tx_q = exp_slv;
        slv_rx_q.delete();
        if (idx == 0) begin
            drv_q0 = exp_tx; bus.tx_data[7:0] = exp_tx[0]; bus.len[3:0] = 4'(lenf);
        end else begin
            drv_q1 = exp_tx; bus.tx_data[15:8] = exp_tx[0]; bus.len[7:4] = 4'(lenf);
        end
        bus.req[idx] = 1'b1;
        for (k = 0; k < 20 && !bus.gnt[idx]; k++) @(negedge clk);
        checks++;
        if (!bus.gnt[idx]) begin
            errors++; $display("FAIL grant_wait req%0d: gnt=%b after %0d clks", idx, bus.gnt, k);
        end
        bus.req[idx] = 1'b0;
        if (stop_rv > 0) begin
            for (k = 0; k < BURST_MAX && m_rv[idx] < stop_rv; k++) @(negedge clk);
            checks++;
            if (m_rv[idx] < stop_rv) begin
                errors++; $display("FAIL rx_valid_wait: got %0d need %0d", m_rv[idx], stop_rv);
            end
        end else begin
            for (k = 0; k < BURST_MAX && m_done[idx] == 0; k++) @(negedge clk);
            checks++;
            if (m_done[idx] == 0) begin
                errors++; $display("FAIL done_wait req%0d: no done within %0d clks", idx, BURST_MAX);
            end
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.sck !== 1'b0)     begin errors++; $display("FAIL rst_sck: got %b want 0", bus.sck); end
        checks++; if (bus.ss_n !== 2'b11)   begin errors++; $display("FAIL rst_ss_n: got %b want 11", bus.ss_n); end
        checks++; if (bus.sdo !== 1'b0)     begin errors++; $display("FAIL rst_sdo: got %b want 0", bus.sdo); end
        checks++; if (bus.gnt !== 2'b00)    begin errors++; $display("FAIL rst_gnt: got %b want 00", bus.gnt); end
        checks++; if (bus.tx_take !== 2'b00) begin errors++; $display("FAIL rst_tx_take: got %b want 00", bus.tx_take); end
        checks++; if (bus.rx_valid !== 2'b00) begin errors++; $display("FAIL rst_rx_valid: got %b want 00", bus.rx_valid); end
        checks++; if (bus.done !== 2'b00)   begin errors++; $display("FAIL rst_done: got %b want 00", bus.done); end
        checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL rst_rx_data: got %h want 00", bus.rx_data); end
    endtask

    task automatic test_loopback_a5();
        logic [7:0] got;
        do_reset();
        exp_tx = {8'hA5}; exp_slv = {};
        run_burst(0, 1, 1'b1, 0);
        got = (m_sdo_q.size() == 1) ? m_sdo_q[0] : 8'hxx;
        checks++; if (got !== 8'hA5) begin errors++; $display("FAIL a5_sdo_bits: got %h (%0d bytes) want a5", got, m_sdo_q.size()); end
        checks++; if (bus.rx_data !== 8'hA5) begin errors++; $display("FAIL a5_rx_data: got %h want a5", bus.rx_data); end
        checks++; if (m_rv[0] != 1 || m_rv[1] != 0) begin errors++; $display("FAIL a5_rx_valid: got %0d/%0d want 1/0", m_rv[0], m_rv[1]); end
        checks++; if (m_done[0] != 1) begin errors++; $display("FAIL a5_done: got %0d want 1", m_done[0]); end
        checks++; if (m_dur != 3 * DIV + 16 * DIV) begin errors++; $display("FAIL a5_duration: got %0d want %0d", m_dur, 3 * DIV + 16 * DIV); end
    endtask

    task automatic test_burst3();
        int bad = 0;
        do_reset();
        exp_tx = {8'h11, 8'h22, 8'h33}; exp_slv = {};
        run_burst(1, 3, 1'b1, 0);
        checks++; if (m_take[1] != 3 || m_take[0] != 0) begin errors++; $display("FAIL b3_tx_take: got %0d/%0d want 0/3", m_take[0], m_take[1]); end
        checks++; if (m_rv[1] != 3) begin errors++; $display("FAIL b3_rx_valid: got %0d want 3", m_rv[1]); end
        checks++; if (m_rises != 24) begin errors++; $display("FAIL b3_sck_rises: got %0d want 24", m_rises); end
        checks++; if (m_ss_rel[1] != 1) begin errors++; $display("FAIL b3_ss_continuous: releases %0d want 1", m_ss_rel[1]); end
        for (int i = 0; i < 3; i++) if (i >= m_rx_q.size() || m_rx_q[i] !== exp_tx[i]) bad++;
        checks++; if (bad != 0 || m_rx_q.size() != 3) begin errors++; $display("FAIL b3_rx_bytes: %0d wrong of %0d want 0 of 3", bad, m_rx_q.size()); end
    endtask

    task automatic test_rr_alternate();
        logic [7:0] a[2], b[2];
        logic [7:0] exp_rx[$];
        int last_served = 1;
        int e, k, bad = 0, ia = 0, ib = 0;
        do_reset();
        loop_en = 1'b1;
        for (int i = 0; i < 2; i++) begin a[i] = 8'($urandom); b[i] = 8'($urandom); end
        drv_q0 = {a[0], a[1]}; drv_q1 = {b[0], b[1]};
        bus.tx_data = {b[0], a[0]};
        bus.len = 8'h11;
        bus.req = 2'b11;
        for (k = 0; k < 4 * BURST_MAX && m_grant_q.size() < 4; k++) @(negedge clk);
        bus.req = 2'b00;
        for (k = 0; k < BURST_MAX && (m_done[0] + m_done[1]) < 4; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            e = (last_served == 0) ? 1 : 0;
            last_served = e;
            if (e == 0) exp_rx.push_back(a[ia++]); else exp_rx.push_back(b[ib++]);
            checks++;
            if (g >= m_grant_q.size() || m_grant_q[g] != e) begin
                errors++; $display("FAIL rr_grant%0d: got %0d want %0d", g, (g < m_grant_q.size()) ? m_grant_q[g] : -1, e);
            end
        end
        for (int i = 0; i < 4; i++) if (i >= m_rx_q.size() || m_rx_q[i] !== exp_rx[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rr_rx_bytes: %0d wrong want 0", bad); end
        checks++; if (m_done[0] != 2 || m_done[1] != 2) begin errors++; $display("FAIL rr_done: got %0d/%0d want 2/2", m_done[0], m_done[1]); end
        checks++; if (m_viol != 0) begin errors++; $display("FAIL rr_exclusive: %0d violations want 0", m_viol); end
    endtask

    task automatic test_len0();
        int bad_rx = 0, bad_slv = 0;
        do_reset();
        exp_tx.delete(); exp_slv.delete();
        for (int i = 0; i < 16; i++) begin exp_tx.push_back(8'($urandom)); exp_slv.push_back(8'($urandom)); end
        run_burst(1, 0, 1'b0, 0);
        for (int i = 0; i < 16; i++) begin
            if (i >= m_rx_q.size() || m_rx_q[i] !== exp_slv[i]) bad_rx++;
            if (i >= slv_rx_q.size() || slv_rx_q[i] !== exp_tx[i]) bad_slv++;
        end
        checks++; if (m_rises != 128) begin errors++; $display("FAIL len0_sck_rises: got %0d want 128", m_rises); end
        checks++; if (m_rv_at_done != 16) begin errors++; $display("FAIL len0_rv_before_done: got %0d want 16", m_rv_at_done); end
        checks++; if (bad_rx != 0) begin errors++; $display("FAIL len0_master_rx: %0d wrong want 0", bad_rx); end
        checks++; if (bad_slv != 0) begin errors++; $display("FAIL len0_slave_rx: %0d wrong want 0", bad_slv); end
        checks++; if (m_dur != 3 * DIV + 16 * 16 * DIV) begin errors++; $display("FAIL len0_duration: got %0d want %0d", m_dur, 3 * DIV + 256 * DIV); end
    endtask

    task automatic test_slave_3c();
        logic [7:0] got;
        do_reset();
        exp_tx = {8'h3C}; exp_slv = {8'hC3};
        run_burst(0, 1, 1'b0, 0);
        got = (slv_rx_q.size() > 0) ? slv_rx_q[0] : 8'hxx;
        checks++; if (got !== 8'h3C) begin errors++; $display("FAIL slv_rdata: got %h want 3c", got); end
        checks++; if (bus.rx_data !== 8'hC3) begin errors++; $display("FAIL slv_master_rx: got %h want c3", bus.rx_data); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        exp_tx.delete(); exp_slv.delete();
        for (int i = 0; i < 4; i++) exp_tx.push_back(8'($urandom));
        run_burst(0, 4, 1'b1, 1);
        repeat (5) @(negedge clk);
        rstb = 1'b0;
        #1;
        checks++; if (bus.sck !== 1'b0)   begin errors++; $display("FAIL mid_rst_sck: got %b want 0", bus.sck); end
        checks++; if (bus.ss_n !== 2'b11) begin errors++; $display("FAIL mid_rst_ss_n: got %b want 11", bus.ss_n); end
        checks++; if (bus.gnt !== 2'b00)  begin errors++; $display("FAIL mid_rst_gnt: got %b want 00", bus.gnt); end
        repeat (3) @(negedge clk);
        rstb = 1'b1;
        repeat (60) @(negedge clk);
        checks++; if (m_done[0] + m_done[1] != 0) begin errors++; $display("FAIL mid_rst_no_done: got %0d want 0", m_done[0] + m_done[1]); end
        checks++; if (bus.ss_n !== 2'b11) begin errors++; $display("FAIL mid_rst_idle: ss_n %b want 11", bus.ss_n); end
    endtask

    task automatic test_random();
        int idx, lenf, n, bad;
        do_reset();
        for (int r = 0; r < 6; r++) begin
            idx  = int'($urandom_range(0, 1));
            lenf = int'($urandom_range(0, 15));
            n    = (lenf == 0) ? 16 : lenf;
            exp_tx.delete(); exp_slv.delete();
            for (int i = 0; i < n; i++) begin exp_tx.push_back(8'($urandom)); exp_slv.push_back(8'($urandom)); end
            run_burst(idx, lenf, 1'b0, 0);
            bad = 0;
            for (int i = 0; i < n; i++) begin
                if (i >= m_sdo_q.size()  || m_sdo_q[i]  !== exp_tx[i])  bad++;
                if (i >= m_rx_q.size()   || m_rx_q[i]   !== exp_slv[i]) bad++;
                if (i >= slv_rx_q.size() || slv_rx_q[i] !== exp_tx[i])  bad++;
            end
            checks++; if (bad != 0) begin errors++; $display("FAIL rnd%0d_data: %0d wrong bytes want 0 (n=%0d)", r, bad, n); end
            checks++; if (m_take[idx] != n || m_rv[idx] != n) begin errors++; $display("FAIL rnd%0d_counts: take %0d rv %0d want %0d", r, m_take[idx], m_rv[idx], n); end
            checks++; if (m_rises != 8 * n) begin errors++; $display("FAIL rnd%0d_sck_rises: got %0d want %0d", r, m_rises, 8 * n); end
            checks++; if (m_dur != 2 * DIV * (1 + 8 * n) + DIV) begin errors++; $display("FAIL rnd%0d_duration: got %0d want %0d", r, m_dur, 2 * DIV * (1 + 8 * n) + DIV); end
            checks++; if (m_ss_rel[idx] != 1 || m_viol != 0) begin errors++; $display("FAIL rnd%0d_ss: releases %0d viol %0d want 1/0", r, m_ss_rel[idx], m_viol); end
        end
    endtask

    initial begin
        #1 rstb = 1'b0;
        test_reset();
        test_loopback_a5();
        test_burst3();
        test_rr_alternate();
        test_len0();
        test_slave_3c();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
